// File: rtl/adc_event_buffer_if.sv
// Output stream of adc_event_buffer: one N_CH*16-bit word per valid/ready transfer.
interface adc_event_buffer_if #(
   parameter int unsigned N_CH = 4
);
   localparam int unsigned DW = N_CH * 16;

   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/adc_event_buffer.sv
// Single-event ADC capture buffer: records samples while adc_read_en is high, then streams header + samples.
// Optional trailer word (XOR of all sample words) enabled by defining ADC_EVT_CHECKSUM_EN.
module adc_event_buffer #(
   parameter int unsigned NUM_DATA               = 1280,
   parameter int unsigned N_CH                   = 4,
   parameter int unsigned ADC_BITS               = 12,
   parameter int unsigned TRIGGER_COUNTER_LENGTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              adc_read_en,
   input  logic [N_CH*ADC_BITS-1:0]          adc_data,
   input  logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_id,
   adc_event_buffer_if.master                m_bus,
   output logic                              busy,
   output logic [15:0]                       drop_count
);
   localparam int unsigned SW = N_CH * ADC_BITS;
   localparam int unsigned OW = N_CH * 16;
   localparam int unsigned CW = $clog2(NUM_DATA + 1);
   localparam int unsigned AW = $clog2(NUM_DATA);
   localparam int unsigned TW = TRIGGER_COUNTER_LENGTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_HEADER,
      S_DRAIN,
      S_TRAILER
   } state_t;

   state_t          state_q, state_d;
   logic            rd_en_q;
   logic [CW-1:0]   count_q, count_d;
   logic            trunc_q, trunc_d;
   logic [TW-1:0]   trig_q, trig_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [OW-1:0]   m_data_q, m_data_d;
   logic            m_valid_q, m_valid_d;
   logic            m_last_q, m_last_d;
   logic            busy_q, busy_d;
   logic [15:0]     drop_q, drop_d;
`ifdef ADC_EVT_CHECKSUM_EN
   logic [OW-1:0]   csum_q, csum_d;
`endif

   logic [SW-1:0]   mem_q [NUM_DATA];
   logic [SW-1:0]   rd_data_q;
   logic            wr_en_c;
   logic [AW-1:0]   wr_addr_c;
   logic [AW-1:0]   rd_addr_c;
   logic            rise_c;
   logic            fire_c;
   logic            last_sample_c;
   logic [OW-1:0]   sample_c;
   logic [63:0]     header_c;

   assign rise_c = adc_read_en & ~rd_en_q;
   assign fire_c = m_valid_q & m_bus.m_ready;

   // Final sample carries m_last only when no trailer follows it.
`ifdef ADC_EVT_CHECKSUM_EN
   assign last_sample_c = 1'b0;
`else
   assign last_sample_c = (idx_q == count_q - CW'(1));
`endif

   assign header_c = {16'hEB90, 16'(trig_q), trunc_q, 15'(count_q), drop_q};

   // Zero-extend each channel into its own 16-bit lane.
   always_comb begin
      sample_c = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         sample_c[c*16 +: 16] = 16'(rd_data_q[c*ADC_BITS +: ADC_BITS]);
      end
   end

   // Read address tracks the next sample to present, so rd_data_q is always ready (prefetch).
   assign rd_addr_c = (idx_d < CW'(NUM_DATA)) ? AW'(idx_d) : '0;

   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_addr_c] <= adc_data;
      end
      rd_data_q <= mem_q[rd_addr_c];
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      trunc_d   = trunc_q;
      trig_d    = trig_q;
      idx_d     = idx_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      drop_d    = drop_q;
      wr_en_c   = 1'b0;
      wr_addr_c = '0;
`ifdef ADC_EVT_CHECKSUM_EN
      csum_d    = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (rise_c) begin
               trig_d    = trigger_id;
               wr_en_c   = 1'b1;
               wr_addr_c = '0;
               count_d   = CW'(1);
               trunc_d   = 1'b0;
               state_d   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (adc_read_en) begin
               if (count_q < CW'(NUM_DATA)) begin
                  wr_en_c   = 1'b1;
                  wr_addr_c = AW'(count_q);
                  count_d   = count_q + CW'(1);
               end else begin
                  trunc_d = 1'b1;
               end
            end else begin
               m_data_d  = OW'(header_c);
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               idx_d     = '0;
               state_d   = S_HEADER;
`ifdef ADC_EVT_CHECKSUM_EN
               csum_d    = '0;
`endif
            end
         end
         S_HEADER: begin
            if (fire_c) begin
               m_data_d = sample_c;
               m_last_d = last_sample_c;
               idx_d    = idx_q + CW'(1);
               state_d  = S_DRAIN;
`ifdef ADC_EVT_CHECKSUM_EN
               csum_d   = csum_q ^ sample_c;
`endif
            end
         end
         S_DRAIN: begin
            if (fire_c) begin
               if (idx_q == count_q) begin
`ifdef ADC_EVT_CHECKSUM_EN
                  m_data_d  = csum_q;
                  m_last_d  = 1'b1;
                  state_d   = S_TRAILER;
`else
                  m_data_d  = '0;
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
                  state_d   = S_IDLE;
`endif
               end else begin
                  m_data_d = sample_c;
                  m_last_d = last_sample_c;
                  idx_d    = idx_q + CW'(1);
`ifdef ADC_EVT_CHECKSUM_EN
                  csum_d   = csum_q ^ sample_c;
`endif
               end
            end
         end
`ifdef ADC_EVT_CHECKSUM_EN
         S_TRAILER: begin
            if (fire_c) begin
               m_data_d  = '0;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // A new window arriving while the previous event is still being sent is dropped.
      if (rise_c && (state_q != S_IDLE) && (state_q != S_CAPTURE) && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         // Treat an already-open window at reset release as not a fresh rising edge.
         rd_en_q   <= 1'b1;
         count_q   <= '0;
         trunc_q   <= 1'b0;
         trig_q    <= '0;
         idx_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         drop_q    <= '0;
`ifdef ADC_EVT_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rd_en_q   <= adc_read_en;
         count_q   <= count_d;
         trunc_q   <= trunc_d;
         trig_q    <= trig_d;
         idx_q     <= idx_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
`ifdef ADC_EVT_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign m_bus.m_data  = m_data_q;
   assign m_bus.m_valid = m_valid_q;
   assign m_bus.m_last  = m_last_q;
   assign busy          = busy_q;
   assign drop_count    = drop_q;
endmodule

// File: tb/tb_adc_event_buffer.sv
// Directed bench for adc_event_buffer with a scoreboard of expected {last, data} words.
module tb_adc_event_buffer;
   localparam int unsigned NUM_DATA = 1280;
   localparam int unsigned N_CH     = 4;
   localparam int unsigned ADC_BITS = 12;
   localparam int unsigned TCL      = 16;
`ifdef ADC_EVT_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adc_read_en = 1'b0;
   logic [47:0] adc_data = '0;
   logic [15:0] trigger_id = '0;
   logic        busy;
   logic [15:0] drop_count;

   adc_event_buffer_if #(.N_CH(N_CH)) bus ();

   adc_event_buffer #(
      .NUM_DATA(NUM_DATA), .N_CH(N_CH), .ADC_BITS(ADC_BITS), .TRIGGER_COUNTER_LENGTH(TCL)
   ) dut (
      .clk(clk), .rst(rst), .adc_read_en(adc_read_en), .adc_data(adc_data),
      .trigger_id(trigger_id), .m_bus(bus), .busy(busy), .drop_count(drop_count)
   );

   always #12 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [64:0] sb[$];
   logic [47:0] stim_q[$];
   logic [15:0] exp_drop = '0;
   bit          rnd_en = 1'b0;
   int          cyc = 0;
   int          hdr_cyc = 0;
   int          last_cyc = 0;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] expand(input logic [47:0] w);
      logic [63:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) r[c*16 +: 16] = {4'b0, w[c*12 +: 12]};
      return r;
   endfunction

   task automatic monitor();
      logic        stall = 1'b0;
      logic [64:0] held = '0;
      logic [64:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            check("stall_valid", 65'(bus.m_valid), 65'd1);
            check("stall_hold", {bus.m_last, bus.m_data}, held);
         end
         if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            check("sb_has_entry", 65'(sb.size() != 0), 65'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("word", {bus.m_last, bus.m_data}, e);
            end
            if (bus.m_data[63:48] == 16'hEB90) hdr_cyc = cyc;
            if (bus.m_last === 1'b1) last_cyc = cyc;
         end
         stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
         held  = {bus.m_last, bus.m_data};
      end
   endtask

   task automatic ready_gen();
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) bus.m_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic fill_ramp(input int n, input int base);
      logic [47:0] w;
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < 4; c++) w[c*12 +: 12] = 12'(base + i*4 + c);
         stim_q.push_back(w);
      end
   endtask

   task automatic push_event(input logic [15:0] tid);
      int          cnt;
      logic        trunc;
      logic [63:0] w;
      logic [63:0] cs;
      cnt   = (stim_q.size() > NUM_DATA) ? int'(NUM_DATA) : stim_q.size();
      trunc = (stim_q.size() > NUM_DATA);
      cs    = '0;
      sb.push_back({1'b0, 16'hEB90, tid, trunc, 15'(cnt), exp_drop});
      for (int i = 0; i < cnt; i++) begin
         w  = expand(stim_q[i]);
         cs = cs ^ w;
         sb.push_back({(EXTRA == 0) && (i == cnt - 1), w});
      end
      if (EXTRA != 0) sb.push_back({1'b1, cs});
   endtask

   task automatic drive_window(input logic [15:0] tid);
      for (int i = 0; i < stim_q.size(); i++) begin
         @(posedge clk);
         #1;
         trigger_id  = tid;
         adc_read_en = 1'b1;
         adc_data    = stim_q[i];
      end
      @(posedge clk);
      #1;
      adc_read_en = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      check("drain_timeout", 65'(n < budget), 65'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_m_valid"}, 65'(bus.m_valid), 65'd0);
      check({tag, "_m_last"}, 65'(bus.m_last), 65'd0);
      check({tag, "_m_data"}, 65'(bus.m_data), 65'd0);
      check({tag, "_busy"}, 65'(busy), 65'd0);
      check({tag, "_drop"}, 65'(drop_count), 65'd0);
   endtask

   initial begin
      bus.m_ready = 1'b1;
      fork
         monitor();
         ready_gen();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Full-depth ramp event, no backpressure, no bubbles
      fill_ramp(1280, 0);
      push_event(16'd7);
      drive_window(16'd7);
      wait_done(3000);
      check("full_no_bubble", 65'(last_cyc - hdr_cyc), 65'(1280 + EXTRA));
      check("full_busy_low", 65'(busy), 65'd0);

      // Over-length window is truncated
      fill_ramp(1300, 100);
      push_event(16'd8);
      drive_window(16'd8);
      wait_done(3000);

      // Random backpressure on a short event
      fill_ramp(10, 7);
      rnd_en = 1'b1;
      push_event(16'd3);
      drive_window(16'd3);
      wait_done(500);
      rnd_en = 1'b0;
      bus.m_ready = 1'b1;

      // Second window during drain is dropped
      fill_ramp(20, 500);
      push_event(16'd9);
      drive_window(16'd9);
      repeat (3) @(posedge clk);
      #1;
      adc_read_en = 1'b1;
      adc_data    = 48'hFFF_FFF_FFF_FFF;
      trigger_id  = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      adc_read_en = 1'b0;
      exp_drop = exp_drop + 16'd1;
      wait_done(500);
      check("drop_count", 65'(drop_count), 65'(exp_drop));
      fill_ramp(5, 900);
      push_event(16'd10);
      drive_window(16'd10);
      wait_done(500);

      // Reset in the middle of capture; window still open at release is ignored
      fill_ramp(500, 1234);
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         trigger_id  = 16'd77;
         adc_read_en = 1'b1;
         adc_data    = stim_q[i];
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midrst");
      rst = 1'b0;
      exp_drop = '0;
      repeat (10) @(posedge clk);
      #1;
      check("open_window_ignored", 65'(busy), 65'd0);
      adc_read_en = 1'b0;
      @(posedge clk);
      #1;
      fill_ramp(3, 42);
      push_event(16'd11);
      drive_window(16'd11);
      wait_done(500);

      // Checksum pattern: samples 1, 2, 4
      stim_q.delete();
      stim_q.push_back(48'h1);
      stim_q.push_back(48'h2);
      stim_q.push_back(48'h4);
      push_event(16'd12);
      drive_window(16'd12);
      wait_done(500);

      check("sb_empty_end", 65'(sb.size()), 65'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
